// File: rtl/capture_wr_ctrl.sv
// capture_wr_ctrl: write side of the ADC capture buffer.
// Takes the sample stream and waits for an optional trigger. Accepted samples
// are packed into the two half-width capture RAMs in 8K (dual) or 16K (split)
// layout. Capture is either one-shot up to the max address or a ring until
// stopped. Completion and the last written address are reported to the
// register block.
module capture_wr_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      capture_start,
  input  logic                      capture_stop,
  input  logic                      store_mode,
  input  logic                      cap_wrap,
  input  logic                      trig_en,
  input  logic                      trig_in,
  input  logic [ADDR_WIDTH-1:0]     capture_max_addr,
  input  logic [DATA_WIDTH-1:0]     adc_data,
  input  logic                      adc_vld,
  output logic [ADDR_WIDTH-2:0]     ram0_waddr,
  output logic [ADDR_WIDTH-2:0]     ram1_waddr,
  output logic [DATA_WIDTH/2-1:0]   ram0_wdata,
  output logic [DATA_WIDTH/2-1:0]   ram1_wdata,
  output logic                      ram0_wr_en,
  output logic                      ram1_wr_en,
  output logic                      capture_busy,
  output logic                      capture_done,
  output logic                      capture_wrapped,
  output logic [ADDR_WIDTH-1:0]     capture_last_addr
);

  localparam int HALF_W = DATA_WIDTH / 2;
  localparam int RAM_AW = ADDR_WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e                state_q,   state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] max_q,     max_d;
  logic [ADDR_WIDTH-1:0] last_q,    last_d;
  logic                  mode_q,    mode_d;
  logic                  wrapped_q, wrapped_d;
  logic                  done_q,    done_d;

  logic [RAM_AW-1:0]     waddr_q,   waddr_d;
  logic [HALF_W-1:0]     wdata0_q,  wdata0_d;
  logic [HALF_W-1:0]     wdata1_q,  wdata1_d;
  logic                  wr_en0_q,  wr_en0_d;
  logic                  wr_en1_q,  wr_en1_d;

  logic                  accept;

  // Next-state, address sequencing and RAM write packing.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    max_d     = max_q;
    last_d    = last_q;
    mode_d    = mode_q;
    wrapped_d = wrapped_q;
    done_d    = done_q;
    waddr_d   = waddr_q;
    wdata0_d  = wdata0_q;
    wdata1_d  = wdata1_q;
    wr_en0_d  = 1'b0;
    wr_en1_d  = 1'b0;
    accept    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (capture_start) begin
          // Mode and limit are frozen here; in 8K mode the limit MSB is dropped.
          mode_d    = store_mode;
          max_d     = store_mode ? {1'b0, capture_max_addr[ADDR_WIDTH-2:0]}
                                 : capture_max_addr;
          wr_addr_d = '0;
          last_d    = '0;
          wrapped_d = 1'b0;
          done_d    = 1'b0;
          state_d   = trig_en ? S_WAIT_TRIG : S_CAPTURE;
        end
      end
      S_WAIT_TRIG: begin
        if (capture_stop) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (trig_in) begin
          state_d = S_CAPTURE;
          accept  = adc_vld;
        end
      end
      S_CAPTURE: begin
        if (capture_stop) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          accept = adc_vld;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      last_d = wr_addr_q;
      if (wr_addr_q == max_q) begin
        if (cap_wrap) begin
          wr_addr_d = '0;
          wrapped_d = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end else begin
        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
      end

      // Both RAMs share one address register; in 16K mode the logical MSB
      // selects which RAM strobes and the lower data half goes to either.
      waddr_d  = wr_addr_q[RAM_AW-1:0];
      wdata0_d = adc_data[HALF_W-1:0];
      if (mode_q) begin
        wr_en0_d = 1'b1;
        wr_en1_d = 1'b1;
        wdata1_d = adc_data[DATA_WIDTH-1:HALF_W];
      end else begin
        wr_en0_d = ~wr_addr_q[ADDR_WIDTH-1];
        wr_en1_d =  wr_addr_q[ADDR_WIDTH-1];
        wdata1_d = adc_data[HALF_W-1:0];
      end
    end
  end

  // State, status and write-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      max_q     <= '0;
      last_q    <= '0;
      mode_q    <= 1'b0;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
      waddr_q   <= '0;
      wdata0_q  <= '0;
      wdata1_q  <= '0;
      wr_en0_q  <= 1'b0;
      wr_en1_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      max_q     <= max_d;
      last_q    <= last_d;
      mode_q    <= mode_d;
      wrapped_q <= wrapped_d;
      done_q    <= done_d;
      waddr_q   <= waddr_d;
      wdata0_q  <= wdata0_d;
      wdata1_q  <= wdata1_d;
      wr_en0_q  <= wr_en0_d;
      wr_en1_q  <= wr_en1_d;
    end
  end

  assign ram0_waddr        = waddr_q;
  assign ram1_waddr        = waddr_q;
  assign ram0_wdata        = wdata0_q;
  assign ram1_wdata        = wdata1_q;
  assign ram0_wr_en        = wr_en0_q;
  assign ram1_wr_en        = wr_en1_q;
  assign capture_busy      = (state_q == S_WAIT_TRIG) || (state_q == S_CAPTURE);
  assign capture_done      = done_q;
  assign capture_wrapped   = wrapped_q;
  assign capture_last_addr = last_q;

endmodule

// File: tb/tb_capture_wr_ctrl.sv
// Bench for capture_wr_ctrl: directed scenarios plus random control traffic,
// checked through a write scoreboard and per-cycle status expectations.
module tb_capture_wr_ctrl;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int HW = DW / 2;
  localparam int RA = AW - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, capture_start, capture_stop, store_mode, cap_wrap;
  logic          trig_en, trig_in, adc_vld;
  logic [AW-1:0] capture_max_addr;
  logic [DW-1:0] adc_data;
  logic [RA-1:0] ram0_waddr, ram1_waddr;
  logic [HW-1:0] ram0_wdata, ram1_wdata;
  logic          ram0_wr_en, ram1_wr_en;
  logic          capture_busy, capture_done, capture_wrapped;
  logic [AW-1:0] capture_last_addr;

  capture_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .capture_start(capture_start), .capture_stop(capture_stop),
    .store_mode(store_mode), .cap_wrap(cap_wrap),
    .trig_en(trig_en), .trig_in(trig_in),
    .capture_max_addr(capture_max_addr),
    .adc_data(adc_data), .adc_vld(adc_vld),
    .ram0_waddr(ram0_waddr), .ram1_waddr(ram1_waddr),
    .ram0_wdata(ram0_wdata), .ram1_wdata(ram1_wdata),
    .ram0_wr_en(ram0_wr_en), .ram1_wr_en(ram1_wr_en),
    .capture_busy(capture_busy), .capture_done(capture_done),
    .capture_wrapped(capture_wrapped), .capture_last_addr(capture_last_addr)
  );

  typedef struct packed {
    logic          en0;
    logic          en1;
    logic [RA-1:0] a0;
    logic [RA-1:0] a1;
    logic [HW-1:0] d0;
    logic [HW-1:0] d1;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_en = 1'b0;

  // Reference model: plain flags and integer addresses.
  bit          m_armed, m_run, m_done, m_wrapped, m_mode;
  int unsigned m_addr, m_last, m_max;
  logic          e_busy, e_done, e_wrapped;
  logic [AW-1:0] e_last;

  function automatic wr_t mk_wr(int unsigned a, logic [DW-1:0] d);
    wr_t w;
    int unsigned half = 1 << RA;
    w    = '0;
    w.a0 = RA'(a % half);
    w.a1 = RA'(a % half);
    if (m_mode) begin
      w.en0 = 1'b1; w.en1 = 1'b1;
      w.d0  = d[HW-1:0]; w.d1 = d[DW-1:HW];
    end else if (a < half) begin
      w.en0 = 1'b1; w.d0 = d[HW-1:0];
    end else begin
      w.en1 = 1'b1; w.d1 = d[HW-1:0];
    end
    return w;
  endfunction

  // Apply this cycle's inputs to the model, then advance one clock.
  task automatic tick();
    wr_t w;
    bit  push = 1'b0;
    bit  acc;
    w = '0;
    if (rst) begin
      m_armed = 0; m_run = 0; m_done = 0; m_wrapped = 0;
      m_addr = 0; m_last = 0; m_mode = 0; m_max = 0;
    end else if (!m_armed && !m_run) begin
      if (capture_start) begin
        m_mode    = store_mode;
        m_max     = store_mode ? (int'(capture_max_addr) % (1 << RA)) : int'(capture_max_addr);
        m_addr    = 0; m_last = 0; m_wrapped = 0; m_done = 0;
        m_armed   = trig_en;
        m_run     = !trig_en;
      end
    end else if (capture_stop) begin
      m_armed = 0; m_run = 0; m_done = 1;
    end else begin
      acc = adc_vld && (m_run || (m_armed && trig_in));
      if (m_armed && trig_in) begin m_armed = 0; m_run = 1; end
      if (acc) begin
        w      = mk_wr(m_addr, adc_data);
        push   = 1'b1;
        m_last = m_addr;
        if (m_addr == m_max) begin
          if (cap_wrap) begin m_addr = 0; m_wrapped = 1; end
          else begin m_run = 0; m_done = 1; end
        end else begin
          m_addr++;
        end
      end
    end
    @(posedge clk);
    if (push) exp_q.push_back(w);
    e_busy    = m_armed || m_run;
    e_done    = m_done;
    e_wrapped = m_wrapped;
    e_last    = AW'(m_last);
    #1;
  endtask

  task automatic cyc(bit st, bit sp, bit v, bit tg, logic [DW-1:0] d);
    capture_start = st; capture_stop = sp; adc_vld = v; trig_in = tg; adc_data = d;
    tick();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, $urandom);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: status every cycle, write strobes against the scoreboard queue.
  always @(negedge clk) begin
    wr_t w;
    bit  bad;
    if (mon_en) begin
      chk("busy",      32'(capture_busy),      32'(e_busy));
      chk("done",      32'(capture_done),      32'(e_done));
      chk("wrapped",   32'(capture_wrapped),   32'(e_wrapped));
      chk("last_addr", 32'(capture_last_addr), 32'(e_last));
      if (ram0_wr_en || ram1_wr_en) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got en0=%0b en1=%0b a=%0h expected no write at %0t",
                   ram0_wr_en, ram1_wr_en, ram0_waddr, $time);
        end else begin
          w   = exp_q.pop_front();
          bad = (w.en0 !== ram0_wr_en) || (w.en1 !== ram1_wr_en) ||
                (w.en0 && ((ram0_waddr !== w.a0) || (ram0_wdata !== w.d0))) ||
                (w.en1 && ((ram1_waddr !== w.a1) || (ram1_wdata !== w.d1)));
          if (bad) begin
            n_bad++;
            $display("FAIL write: got en=%0b%0b a0=%0h d0=%0h a1=%0h d1=%0h expected en=%0b%0b a0=%0h d0=%0h a1=%0h d1=%0h at %0t",
                     ram0_wr_en, ram1_wr_en, ram0_waddr, ram0_wdata, ram1_waddr, ram1_wdata,
                     w.en0, w.en1, w.a0, w.d0, w.a1, w.d1, $time);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; capture_start = 0; capture_stop = 0; store_mode = 0; cap_wrap = 0;
    trig_en = 0; trig_in = 0; adc_vld = 0; capture_max_addr = '0; adc_data = '0;

    tick();
    mon_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    idle(2);

    // 8K one-shot: 4 dual writes, samples 4 and 5 dropped.
    store_mode = 1; cap_wrap = 0; trig_en = 0; capture_max_addr = AW'(3);
    cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 32'h1111_0000 + DW'(i));
    idle(3);

    // 16K split across the RAM boundary at 0x2000.
    store_mode = 0; capture_max_addr = AW'(14'h2001);
    cyc(1, 0, 0, 0, '0);
    guard = 0;
    while (m_run && guard < 20000) begin
      cyc(0, 0, $urandom_range(0, 7) != 0, 0, $urandom);
      guard++;
    end
    idle(3);

    // Trigger: nothing written before trig_in, trigger sample lands at 0.
    store_mode = 1; trig_en = 1; capture_max_addr = AW'(15);
    cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, $urandom);
    cyc(0, 0, 1, 1, 32'hABCD_0000);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, $urandom);
    cyc(0, 1, 0, 0, '0);
    idle(2);

    // Ring: 0..7 then 0..4, stop-cycle sample dropped.
    trig_en = 0; cap_wrap = 1; capture_max_addr = AW'(7);
    cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < 13; i++) cyc(0, 0, 1, 0, $urandom);
    cyc(0, 1, 1, 0, $urandom);
    idle(2);

    // Restart from DONE, then a start while busy is ignored.
    cap_wrap = 0; capture_max_addr = AW'(5);
    cyc(1, 0, 1, 0, $urandom);
    cyc(0, 0, 1, 0, $urandom);
    cyc(1, 0, 1, 0, $urandom);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, $urandom);
    idle(2);

    // Stop in WAIT_TRIG, even with trigger present.
    trig_en = 1;
    cyc(1, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, $urandom);
    cyc(0, 1, 1, 1, $urandom);
    idle(2);

    // Reset mid-capture.
    trig_en = 0; cap_wrap = 1;
    cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, $urandom);
    rst = 1'b1;
    cyc(0, 0, 1, 0, $urandom);
    rst = 1'b0;
    idle(3);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if (!m_armed && !m_run) begin
        store_mode = 1'($urandom_range(0, 1));
        cap_wrap   = 1'($urandom_range(0, 1));
        trig_en    = 1'($urandom_range(0, 1));
        capture_max_addr = store_mode ? {1'($urandom_range(0, 1)), 13'($urandom_range(0, 20))}
                                      : AW'($urandom_range(0, 20));
      end
      rst = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom);
    end
    rst = 1'b0;
    idle(4);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
